// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Single-port word-organised data memory behind a
//                valid/ready request/response handshake. Byte-lane stores,
//                aligned-word loads, error response on misaligned or
//                out-of-range addresses.
//                Optional macro DMEM_WAIT_EN inserts WAIT_CYCLES wait
//                states per access through a WAIT state and down-counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [31:0] C_BYTES = 32'(4 * DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RESP = 2'd2;
`ifdef DMEM_WAIT_EN
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [3:0] C_WAIT = 4'(WAIT_CYCLES);
`endif

    // Out-of-range parameters leave an extra, empty scope in the elaborated
    // hierarchy so a bad configuration is easy to spot.
    if (DEPTH < 4 || DEPTH > 4096 || (DEPTH & (DEPTH - 1)) != 0 ||
        WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_params
    end

    logic [1:0]  state_q, state_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q,   err_d;

    logic [31:0] mem [DEPTH];

    // Access currently being served: straight from the inputs on the accept
    // edge, from the latched copy while waiting.
    logic          w_we;
    logic [31:0]   w_addr;
    logic [31:0]   w_wdata;
    logic [3:0]    w_be;
    logic          w_err;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_merged;
    logic          w_enter_resp;

`ifdef DMEM_WAIT_EN
    logic [3:0]  cnt_q,   cnt_d;
    logic        we_q,    we_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q,    be_d;
`endif

    // State, response and (optional) latched-request registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
`ifdef DMEM_WAIT_EN
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef DMEM_WAIT_EN
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
`endif
        end
    end

    // Next-state logic; w_enter_resp marks the edge that commits the access
    always_comb begin
        state_d      = state_q;
        w_enter_resp = 1'b0;
`ifdef DMEM_WAIT_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
`ifdef DMEM_WAIT_EN
                    if (C_WAIT == 4'd0) begin
                        state_d      = S_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = C_WAIT;
                    end
`else
                    state_d      = S_RESP;
                    w_enter_resp = 1'b1;
`endif
                end
            end
`ifdef DMEM_WAIT_EN
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d      = S_RESP;
                    w_enter_resp = 1'b1;
                end
            end
`endif
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef DMEM_WAIT_EN
    // Capture the request on the accept edge for use during wait states
    always_comb begin
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        if (state_q == S_IDLE && req_valid) begin
            we_d    = req_we;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            be_d    = req_be;
        end
    end
`endif

    // Select the access source and decode address, error and merged store word
    always_comb begin
        w_we    = req_we;
        w_addr  = req_addr;
        w_wdata = req_wdata;
        w_be    = req_be;
`ifdef DMEM_WAIT_EN
        if (state_q == S_WAIT) begin
            w_we    = we_q;
            w_addr  = addr_q;
            w_wdata = wdata_q;
            w_be    = be_q;
        end
`endif
        w_err    = (w_addr[1:0] != 2'b00) || (w_addr >= C_BYTES);
        w_idx    = w_addr[AW+1:2];
        w_merged = mem[w_idx];
        for (int i = 0; i < 4; i++) begin
            if (w_be[i]) begin
                w_merged[8*i +: 8] = w_wdata[8*i +: 8];
            end
        end
    end

    // Response data/error are captured on the edge entering RESP and held
    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (w_enter_resp) begin
            err_d   = w_err;
            rdata_d = (w_err || w_we) ? 32'd0 : mem[w_idx];
        end
    end

    // Memory array: no reset; a store commits only on a non-reset edge entering RESP
    always_ff @(posedge clk) begin
        if (!reset && w_enter_resp && w_we && !w_err) begin
            mem[w_idx] <= w_merged;
        end
    end

    // Handshake outputs decoded from the current state
    always_comb begin
        req_ready = (state_q == S_IDLE);
        rsp_valid = (state_q == S_RESP);
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Self-checking bench for dmem_responder. Directed scenarios
//                plus randomized accesses compared against a word-array
//                reference model of the memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int DEPTH       = 64;
    localparam int WAIT_CYCLES = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [31:0] model [DEPTH];
    int          exp_lat;

    dmem_responder #(
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Random values on the request pins while the responder is busy
    task automatic junk_request();
        req_valid = 1'b1;
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = 32'($urandom_range(0, 63)) << 2;
        req_wdata = $urandom();
        req_be    = 4'($urandom());
    endtask

    function automatic bit addr_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'(4 * DEPTH));
    endfunction

    // One full transaction with hold cycles of rsp_ready=0 in RESP
    task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int hold, input string tag);
        bit          e_err;
        logic [31:0] e_rd;
        logic [31:0] w;
        int          lat;
        e_err = addr_bad(addr);
        e_rd  = (e_err || we) ? 32'd0 : model[addr / 4];

        chk({tag, "_req_ready_idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        @(posedge clk); #1;

        lat = 1;
        while (!rsp_valid && lat < 40) begin
            chk({tag, "_req_ready_busy"}, 32'(req_ready), 32'd0);
            junk_request();
            rsp_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_rdata"}, rsp_rdata, e_rd);
        chk({tag, "_err"}, 32'(rsp_err), 32'(e_err));

        for (int h = 0; h < hold; h++) begin
            junk_request();
            rsp_ready = 1'b0;
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
            chk({tag, "_hold_rdata"}, rsp_rdata, e_rd);
            chk({tag, "_hold_err"}, 32'(rsp_err), 32'(e_err));
        end

        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);

        if (we && !e_err) begin
            w = model[addr / 4];
            for (int b = 0; b < 4; b++) begin
                if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
            end
            model[addr / 4] = w;
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int          sel;

`ifdef DMEM_WAIT_EN
        exp_lat = (WAIT_CYCLES == 0) ? 1 : WAIT_CYCLES + 1;
`else
        exp_lat = 1;
`endif
        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        req_be    = 4'd0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);

        // Give every word a known value
        for (int i = 0; i < DEPTH; i++) begin
            access(1'b1, 32'(i * 4), $urandom(), 4'hF, 0, "init");
        end

        // Full-word store then load back
        access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, "st10");
        access(1'b0, 32'h10, 32'd0, 4'h0, 0, "ld10");
        chk("ld10_model", model[4], 32'hDEADBEEF);

        // Partial-lane store merge
        access(1'b1, 32'h20, 32'h11223344, 4'hF, 0, "st20a");
        access(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1, "st20b");
        access(1'b0, 32'h20, 32'd0, 4'h0, 0, "ld20");
        chk("ld20_model", model[8], 32'h11BB33DD);

        // Misaligned and out-of-range loads, then stores that must not write
        access(1'b0, 32'h22, 32'd0, 4'h0, 0, "ld22_err");
        access(1'b0, 32'h100, 32'd0, 4'h0, 0, "ld100_err");
        access(1'b1, 32'h104, 32'hCAFEF00D, 4'hF, 0, "st104_err");
        access(1'b1, 32'h21, 32'h0BADC0DE, 4'hF, 0, "st21_err");
        access(1'b0, 32'h04, 32'd0, 4'h0, 0, "ld04");
        access(1'b0, 32'h20, 32'd0, 4'h0, 0, "ld20_again");

        // Store with no lanes enabled
        access(1'b1, 32'h10, 32'h12345678, 4'h0, 0, "st_be0");
        access(1'b0, 32'h10, 32'd0, 4'h0, 0, "ld_be0");

        // Back-pressure on the response for four cycles
        access(1'b0, 32'h20, 32'd0, 4'h0, 4, "ld_hold4");

        // Reset one cycle after accepting a store: only a store that has
        // already reached RESP (single-cycle latency) is committed.
        a = 32'h30;
        d = model[12] ^ 32'hFFFF_FFFF;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = a;
        req_wdata = d;
        req_be    = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset     = 1'b1;
        @(posedge clk); #1;
        reset     = 1'b0;
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_rdata", rsp_rdata, 32'd0);
        chk("midrst_err", 32'(rsp_err), 32'd0);
        if (exp_lat == 1) model[12] = d;
        access(1'b0, a, 32'd0, 4'h0, 0, "midrst_ld30");

        // Randomized traffic against the model
        for (int n = 0; n < 150; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0) begin
                a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
            end else if (sel == 1) begin
                a = 32'(4 * DEPTH) + 32'($urandom_range(0, 4000));
            end else begin
                a = 32'($urandom_range(0, DEPTH - 1)) << 2;
            end
            access(1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom()),
                   int'($urandom_range(0, 3)), "rand");
        end

        // Final sweep of every word
        for (int i = 0; i < DEPTH; i++) begin
            access(1'b0, 32'(i * 4), 32'd0, 4'h0, 0, "sweep");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
